// File: rtl/hc08_share_arb_pkg.sv
// Shared types and helpers for the hc08 gate-bank arbiter.
package hc08_share_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Index width with a floor of one bit so a single requester still has an id port.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/hc08_share_arb_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo NREQ.
module hc08_share_arb_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            valid,
  output logic [IDW-1:0]  idx,
  output logic [NREQ-1:0] onehot
);

  int              p;
  int              c;
  logic [IDW-1:0]  ci;

  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    p      = int'(ptr);
    c      = 0;
    ci     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      c  = (p + i) % NREQ;
      ci = IDW'(c);
      if (!valid && req[ci]) begin
        valid = 1'b1;
        idx   = ci;
      end
    end
    if (valid) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/hc08_share_arb.sv
// Round-robin sequencer sharing one bank of 74HC08 AND gates among NREQ requesters.
//  state   | meaning
//  IDLE    | waiting for any req; picks winner, captures operands, pulses gnt
//  EXEC    | gate bank evaluates captured operands; result registered at end
//  RESP    | rsp_valid held with data/id until rsp_ready
module hc08_share_arb
  import hc08_share_arb_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 4,
  localparam int IDW   = clog2_min1(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_flat,
  input  logic [NREQ*WIDTH-1:0] b_flat,
  output logic [NREQ-1:0]       gnt,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   k;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] gate_y;

  logic             pick_valid;
  logic [IDW-1:0]   pick_idx;
  logic [NREQ-1:0]  pick_onehot;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;

  hc08_share_arb_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign a_sel = a_flat[pick_idx*WIDTH +: WIDTH];
  assign b_sel = b_flat[pick_idx*WIDTH +: WIDTH];

  // One 2-input AND per bit; only the captured operand registers reach the gates.
  for (genvar g = 0; g < WIDTH; g++) begin : g_hc08
    assign gate_y[g] = op_a[g] & op_b[g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= IDW'(NREQ - 1);
      k         <= '0;
      op_a      <= '0;
      op_b      <= '0;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      busy      <= 1'b0;
    end else begin
      gnt <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            op_a  <= a_sel;
            op_b  <= b_sel;
            k     <= pick_idx;
            ptr   <= pick_idx;
            gnt   <= pick_onehot;
            busy  <= 1'b1;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data  <= gate_y;
          rsp_id    <= k;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
